// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: FSM encoding, gate op codes
// and the reference gate function used by both the checker and gate benches.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;
  localparam int OP_NOR  = 4;
  localparam int OP_XNOR = 5;

  // Reduces the low n bits of vec with the selected gate function.
  function automatic logic gate_ref(input int op, input logic [7:0] vec, input int n);
    logic r_and;
    logic r_or;
    logic r_xor;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        r_and = r_and & vec[i];
        r_or  = r_or | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (op)
      OP_AND:  return r_and;
      OP_OR:   return r_or;
      OP_XOR:  return r_xor;
      OP_NAND: return ~r_and;
      OP_NOR:  return ~r_or;
      OP_XNOR: return ~r_xor;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of an N_IN-input gate; reusable by gate benches.
module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int GATE_OP = 0
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp_y
);

  logic [7:0] vec_ext;

  always_comb begin
    vec_ext            = '0;
    vec_ext[N_IN-1:0]  = vec;
    exp_y              = gate_ref(GATE_OP, vec_ext, N_IN);
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Exhaustive self-test driver for an N_IN-input gate: walks every input vector,
// waits SETTLE_CYC+1 cycles, samples dut_y against the reference and logs errors.
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2,
  parameter int GATE_OP    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            exp_y;

  gate_ref_model #(.N_IN(N_IN), .GATE_OP(GATE_OP)) u_ref (
    .vec   (vec_q),
    .exp_y (exp_y)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        vec_d = '0;
        if (start) begin
          cnt_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYC)) state_d = ST_SAMPLE;
        else                         cnt_d   = cnt_q + 4'd1;
      end
      ST_SAMPLE: begin
        if (dut_y != exp_y) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = vec_q;
          end
        end
        // pass must include the verdict of this final sample, hence err_d
        if (vec_q == '1) begin
          vec_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dut_in         = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: AND checker against good/stuck DUTs,
// start/reset corner cases, and XOR checkers against a 2-cycle-late XOR DUT.
module tb_gate_truth_table_checker;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   mode;
  int   cyc;
  int   cyc2;

  logic       start_m, y_m, busy_m, done_m, pass_m, fv_m;
  logic [2:0] din_m, ffv_m;
  logic [3:0] err_m;

  logic       start_x, y_x0, y_x2;
  logic       busy_x0, done_x0, pass_x0, fv_x0, busy_x2, done_x2, pass_x2, fv_x2;
  logic [2:0] din_x0, ffv_x0, din_x2, ffv_x2;
  logic [3:0] err_x0, err_x2;
  logic       p1_x0, p2_x0, p1_x2, p2_x2;

  gate_truth_table_checker u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .dut_in(din_m), .dut_y(y_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
    .fail_valid(fv_m), .first_fail_vec(ffv_m)
  );

  gate_truth_table_checker #(.N_IN(3), .SETTLE_CYC(0), .GATE_OP(2)) u_x0 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .dut_in(din_x0), .dut_y(y_x0),
    .busy(busy_x0), .done(done_x0), .pass(pass_x0), .err_count(err_x0),
    .fail_valid(fv_x0), .first_fail_vec(ffv_x0)
  );

  gate_truth_table_checker #(.N_IN(3), .SETTLE_CYC(2), .GATE_OP(2)) u_x2 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .dut_in(din_x2), .dut_y(y_x2),
    .busy(busy_x2), .done(done_x2), .pass(pass_x2), .err_count(err_x2),
    .fail_valid(fv_x2), .first_fail_vec(ffv_x2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: correct AND, 1: stuck-at-0, 2: stuck-at-1
  assign y_m = (mode == 0) ? &din_m : (mode == 1) ? 1'b0 : 1'b1;

  // XOR gate whose output lags its inputs by two clock cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_x0 <= 1'b0; p2_x0 <= 1'b0; p1_x2 <= 1'b0; p2_x2 <= 1'b0;
    end else begin
      p1_x0 <= ^din_x0; p2_x0 <= p1_x0;
      p1_x2 <= ^din_x2; p2_x2 <= p1_x2;
    end
  end
  assign y_x0 = p2_x0;
  assign y_x2 = p2_x2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic wait_done(input int which, input int budget, output int c);
    logic d;
    c = 0;
    d = 1'b0;
    while (!d && c < budget) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      d = (which == 0) ? done_m : (which == 1) ? done_x0 : done_x2;
    end
    if (!d) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_main();
    start_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_m = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; mode = 0;
    rst_n = 1'b0; start_m = 1'b0; start_x = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_pass", pass_m, 0);
    chk("rst_err", err_m, 0);
    chk("rst_din", din_m, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: good AND, dut_in steps every 4 cycles, done 32 cycles after start edge
    pulse_main();
    chk("t1_busy", busy_m, 1);
    cyc = 0;
    while (!done_m && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!done_m && (cyc % 4) == 1) chk($sformatf("t1_din_%0d", cyc), din_m, cyc / 4);
    end
    chk("t1_len", cyc, 32);
    chk("t1_pass", pass_m, 1);
    chk("t1_err", err_m, 0);
    chk("t1_fv", fv_m, 0);
    chk("t1_din_done", din_m, 0);
    @(negedge clk);
    chk("t1_done_pulse", done_m, 0);
    chk("t1_busy_end", busy_m, 0);

    // 2: stuck-at-0
    mode = 1;
    pulse_main();
    wait_done(0, 60, cyc);
    chk("t2_err", err_m, 1);
    chk("t2_ffv", ffv_m, 3'b111);
    chk("t2_fv", fv_m, 1);
    chk("t2_pass", pass_m, 0);
    @(negedge clk);

    // 3: stuck-at-1
    mode = 2;
    pulse_main();
    wait_done(0, 60, cyc);
    chk("t3_err", err_m, 7);
    chk("t3_ffv", ffv_m, 3'b000);
    chk("t3_pass", pass_m, 0);
    repeat (3) @(negedge clk);
    chk("t3_hold_err", err_m, 7);

    // 4: start held high through the run and the DONE cycle
    mode = 0;
    start_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, 60, cyc);
    chk("t4_len", cyc, 32);
    chk("t4_pass", pass_m, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t4_idle_busy", busy_m, 0);
    chk("t4_idle_done", done_m, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_restart_busy", busy_m, 1);
    chk("t4_restart_pass", pass_m, 0);
    start_m = 1'b0;
    wait_done(0, 60, cyc);
    chk("t4_len2", cyc, 32);
    chk("t4_pass2", pass_m, 1);
    @(negedge clk);

    // 5: reset while dut_in == 4
    pulse_main();
    cyc = 0;
    while (din_m != 3'd4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_reached4", din_m, 4);
    rst_n = 1'b0;
    #1;
    chk("t5_din", din_m, 0);
    chk("t5_busy", busy_m, 0);
    chk("t5_pass", pass_m, 0);
    chk("t5_err", err_m, 0);
    chk("t5_done", done_m, 0);
    cyc2 = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_m) cyc2++;
    end
    chk("t5_no_done", cyc2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_main();
    wait_done(0, 60, cyc);
    chk("t5_len", cyc, 32);
    chk("t5_pass2", pass_m, 1);
    chk("t5_err2", err_m, 0);

    // 6: XOR lagging 2 cycles; SETTLE_CYC=0 sees stale output, SETTLE_CYC=2 does not
    @(negedge clk);
    start_x = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_x = 1'b0;
    wait_done(1, 40, cyc);
    chk("t6_len0", cyc, 16);
    chk("t6_err0_nz", err_x0 != 0, 1);
    chk("t6_err0", err_x0, 5);
    chk("t6_ffv0", ffv_x0, 1);
    chk("t6_pass0", pass_x0, 0);
    wait_done(2, 40, cyc2);
    chk("t6_len2", cyc + cyc2, 32);
    chk("t6_pass2", pass_x2, 1);
    chk("t6_err2", err_x2, 0);
    chk("t6_fv2", fv_x2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
